// File: rtl/player_controller.sv
// Per-player sprite position and animation state, advanced once per video frame.
// Buttons are synchronized; jump is edge-triggered and latched until the next frame tick.
module player_controller #(
    parameter logic [9:0] START_X  = 10'd100,
    parameter logic [9:0] GROUND_Y = 10'd360,
    parameter logic [9:0] SPRITE_W = 10'd64,
    parameter logic [9:0] SCREEN_W = 10'd640,
    parameter logic [9:0] SPEED    = 10'd4,
    parameter logic [5:0] JUMP_V0  = 6'd12,
    parameter logic [5:0] GRAVITY  = 6'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] p_x,
    output logic [9:0] p_y,
    output logic [3:0] p_state
);

    typedef enum logic [1:0] {StGround, StRise, StFall} fsm_e;

    localparam logic [9:0] X_MAX = SCREEN_W - SPRITE_W;

    logic       r_left_s1, r_left_s2;
    logic       r_right_s1, r_right_s2;
    logic       r_jump_s1, r_jump_s2, r_jump_s3;
    logic       r_jump_pending;
    fsm_e       r_fsm;
    logic [5:0] r_vel;
    logic [9:0] r_x, r_y;
    logic [3:0] r_state;

    logic       w_jump_edge;
    logic [9:0] w_x_sub;
    logic [10:0] w_x_add;
    logic [10:0] w_fall_sum;
    logic [5:0] w_vel_dec;
    logic [9:0] w_x_next, w_y_next;
    logic [5:0] w_vel_next;
    logic [3:0] w_state_next;
    fsm_e       w_fsm_next;

    assign w_jump_edge = r_jump_s2 & ~r_jump_s3;
    assign w_x_sub     = r_x - SPEED;
    assign w_x_add     = {1'b0, r_x} + {1'b0, SPEED};
    assign w_fall_sum  = {1'b0, r_y} + {5'b0, r_vel} + {5'b0, GRAVITY};
    assign w_vel_dec   = r_vel - GRAVITY;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_left_s1  <= 1'b0;
            r_left_s2  <= 1'b0;
            r_right_s1 <= 1'b0;
            r_right_s2 <= 1'b0;
            r_jump_s1  <= 1'b0;
            r_jump_s2  <= 1'b0;
            r_jump_s3  <= 1'b0;
        end else begin
            r_left_s1  <= btn_left;
            r_left_s2  <= r_left_s1;
            r_right_s1 <= btn_right;
            r_right_s2 <= r_right_s1;
            r_jump_s1  <= btn_jump;
            r_jump_s2  <= r_jump_s1;
            r_jump_s3  <= r_jump_s2;
        end
    end

    // An edge coinciding with the tick survives the clear and counts for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_jump_pending <= 1'b0;
        end else begin
            r_jump_pending <= w_jump_edge | (r_jump_pending & ~frame_tick);
        end
    end

    always_comb begin
        w_x_next = r_x;
        if (r_left_s2 && !r_right_s2) begin
            w_x_next = (r_x >= SPEED) ? w_x_sub : 10'd0;
        end else if (r_right_s2 && !r_left_s2) begin
            w_x_next = (w_x_add > {1'b0, X_MAX}) ? X_MAX : w_x_add[9:0];
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_vel_next   = r_vel;
        w_y_next     = r_y;
        w_state_next = r_state;
        unique case (r_fsm)
            StGround: begin
                if (r_jump_pending) begin
                    w_vel_next   = JUMP_V0;
                    w_state_next = 4'd1;
                    w_fsm_next   = StRise;
                end else begin
                    w_y_next = GROUND_Y;
                end
            end
            StRise: begin
                w_y_next   = r_y - {4'b0, r_vel};
                w_vel_next = w_vel_dec;
                if (w_vel_dec == 6'd0) begin
                    w_fsm_next = StFall;
                end
            end
            StFall: begin
                if (w_fall_sum >= {1'b0, GROUND_Y}) begin
                    w_y_next     = GROUND_Y;
                    w_vel_next   = 6'd0;
                    w_state_next = 4'd0;
                    w_fsm_next   = StGround;
                end else begin
                    w_y_next   = w_fall_sum[9:0];
                    w_vel_next = r_vel + GRAVITY;
                end
            end
            default: begin
                w_fsm_next = StGround;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm   <= StGround;
            r_vel   <= 6'd0;
            r_x     <= START_X;
            r_y     <= GROUND_Y;
            r_state <= 4'd0;
        end else if (frame_tick) begin
            r_fsm   <= w_fsm_next;
            r_vel   <= w_vel_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_state <= w_state_next;
        end
    end

    assign p_x     = r_x;
    assign p_y     = r_y;
    assign p_state = r_state;

endmodule
